// File: rtl/dosificador_pkg.sv
// Shared encodings and helpers for the RGB dose sequencer.
package dosificador_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN_R = 3'd1,
    RUN_G = 3'd2,
    RUN_B = 3'd3,
    GAP   = 3'd4
  } state_t;

  // Bit positions of each colour inside the motor vector.
  localparam int COL_R = 2;
  localparam int COL_G = 1;
  localparam int COL_B = 0;

  // First colour after 'cur' with a nonzero dose, or IDLE if none remain.
  // From IDLE the search starts at R.
  function automatic state_t next_run(state_t cur, logic [4:0] r, logic [4:0] g,
                                      logic [4:0] b);
    state_t n;
    n = IDLE;
    case (cur)
      IDLE: begin
        if (r != '0)      n = RUN_R;
        else if (g != '0) n = RUN_G;
        else if (b != '0) n = RUN_B;
      end
      RUN_R: begin
        if (g != '0)      n = RUN_G;
        else if (b != '0) n = RUN_B;
      end
      RUN_G: begin
        if (b != '0)      n = RUN_B;
      end
      default: n = IDLE;
    endcase
    return n;
  endfunction

  // One-hot motor enable for a run state; all-off otherwise.
  function automatic logic [2:0] motor_of(state_t s);
    logic [2:0] m;
    m = 3'b000;
    case (s)
      RUN_R:   m[COL_R] = 1'b1;
      RUN_G:   m[COL_G] = 1'b1;
      RUN_B:   m[COL_B] = 1'b1;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dosificador_rgb_base_tiempo.sv
// Dose-unit prescaler: counts 0..UNIT_TICKS-1 while enabled and strobes
// tick on the last count (the wrap).
module base_tiempo #(
  parameter int UNIT_TICKS = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;
  localparam logic [PW-1:0] LAST = PW'(UNIT_TICKS - 1);

  logic [PW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Free count with synchronous clear; wraps back to zero on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (en)     cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
  end

endmodule

// File: rtl/dosificador_rgb.sv
// RGB dose sequencer: runs R, G, B motors in turn for amount*UNIT_TICKS
// cycles each, with an optional all-off gap between active colours.
module dosificador_rgb
  import dosificador_pkg::*;
#(
  parameter int UNIT_TICKS = 50000,
  parameter int GAP_TICKS  = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [4:0] ciclos_R,
  input  logic [4:0] ciclos_G,
  input  logic [4:0] ciclos_B,
  output logic [2:0] motor,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic [2:0] fase
);

  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  state_t        state, col, nxt_run, nxt_start;
  logic [4:0]    amt_r, amt_g, amt_b, cur_amt, units;
  logic [GW-1:0] gap_cnt;
  logic          tick, presc_clr, presc_en, unit_last;

  // Prescaler is only live in a run state. Holding it clear in IDLE/GAP (and
  // on abort) guarantees it starts at zero on every run-state entry; a
  // run-to-run hop happens on the wrap, which also leaves it at zero.
  assign presc_en  = (state == RUN_R) || (state == RUN_G) || (state == RUN_B);
  assign presc_clr = (state == IDLE) || (state == GAP) || abort;

  base_tiempo #(.UNIT_TICKS(UNIT_TICKS)) u_base (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (presc_clr),
    .en    (presc_en),
    .tick  (tick)
  );

  // Dose of the colour currently running and the colour that follows it.
  always_comb begin
    cur_amt = '0;
    case (state)
      RUN_R:   cur_amt = amt_r;
      RUN_G:   cur_amt = amt_g;
      RUN_B:   cur_amt = amt_b;
      default: cur_amt = '0;
    endcase
    nxt_run   = next_run((state == GAP) ? col : state, amt_r, amt_g, amt_b);
    nxt_start = next_run(IDLE, ciclos_R, ciclos_G, ciclos_B);
  end

  assign unit_last = tick && (units == cur_amt - 5'd1);
  assign fase      = state;

  // Sequencer FSM with unit/gap counters and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      col     <= IDLE;
      amt_r   <= '0;
      amt_g   <= '0;
      amt_b   <= '0;
      units   <= '0;
      gap_cnt <= '0;
      motor   <= 3'b000;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (state != IDLE && abort) begin
        // Abort beats everything, including a run's final cycle.
        state   <= IDLE;
        units   <= '0;
        gap_cnt <= '0;
        motor   <= 3'b000;
        busy    <= 1'b0;
        aborted <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              amt_r <= ciclos_R;
              amt_g <= ciclos_G;
              amt_b <= ciclos_B;
              units <= '0;
              if (nxt_start == IDLE) begin
                done <= 1'b1;
              end else begin
                state <= nxt_start;
                motor <= motor_of(nxt_start);
                busy  <= 1'b1;
              end
            end
          end
          RUN_R, RUN_G, RUN_B: begin
            if (unit_last) begin
              units <= '0;
              if (nxt_run == IDLE) begin
                state <= IDLE;
                motor <= 3'b000;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else if (GAP_TICKS == 0) begin
                state <= nxt_run;
                motor <= motor_of(nxt_run);
              end else begin
                state   <= GAP;
                col     <= state;
                gap_cnt <= '0;
                motor   <= 3'b000;
              end
            end else if (tick) begin
              units <= units + 5'd1;
            end
          end
          GAP: begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt <= '0;
              state   <= nxt_run;
              motor   <= motor_of(nxt_run);
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
          default: begin
            state <= IDLE;
            motor <= 3'b000;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dosificador_rgb.sv
// Bench for dosificador_rgb: a cycle-plan model (list of expected output
// cycles built from the dose amounts) checked every cycle, plus literal
// checkpoints from the directed scenarios and a randomized soak.
module tb_dosificador_rgb;

  localparam int UNIT = 4;
  localparam int GAPT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] cr = '0, cg = '0, cb = '0;
  logic [2:0] motor, fase;
  logic       busy, done, aborted;

  always #5 clk = ~clk;

  dosificador_rgb #(.UNIT_TICKS(UNIT), .GAP_TICKS(GAPT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .ciclos_R (cr),
    .ciclos_G (cg),
    .ciclos_B (cb),
    .motor    (motor),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .fase     (fase)
  );

  typedef struct packed {
    logic [2:0] motor;
    logic [2:0] fase;
    logic       busy;
    logic       done;
    logic       aborted;
  } obs_t;

  localparam obs_t IDLE_O = '0;

  obs_t cur = '0;
  obs_t plan[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   c0 = 0;
  bit   chk_en = 1'b0;

  // Expected output for every cycle of a run, straight from the dose rules.
  function automatic void build(logic [4:0] r, logic [4:0] g, logic [4:0] b);
    logic [4:0] a[3];
    bit any;
    a[0] = r; a[1] = g; a[2] = b;
    any = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (a[i] != 0) begin
        if (any) repeat (GAPT) plan.push_back('{3'b000, 3'd4, 1'b1, 1'b0, 1'b0});
        repeat (int'(a[i]) * UNIT) plan.push_back('{3'b100 >> i, 3'(i + 1), 1'b1, 1'b0, 1'b0});
        any = 1'b1;
      end
    end
    plan.push_back('{3'b000, 3'd0, 1'b0, 1'b1, 1'b0});
  endfunction

  // Reference model: 'cur' is what the outputs must be in the cycle that follows.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur = IDLE_O;
      plan.delete();
    end else if (cur.busy && abort) begin
      plan.delete();
      cur = '{3'b000, 3'd0, 1'b0, 1'b0, 1'b1};
    end else if (plan.size() > 0) begin
      cur = plan.pop_front();
    end else if (start && !abort) begin
      build(cr, cg, cb);
      cur = plan.pop_front();
    end else begin
      cur = IDLE_O;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if ({motor, fase, busy, done, aborted} !== cur) begin
        n_bad++;
        $display("FAIL model cyc=%0d got m=%b f=%0d b=%b d=%b a=%b want m=%b f=%0d b=%b d=%b a=%b",
                 cyc - c0, motor, fase, busy, done, aborted,
                 cur.motor, cur.fase, cur.busy, cur.done, cur.aborted);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic wait_to(input int n);
    while (cyc < c0 + n) @(negedge clk);
  endtask

  // Pulse start for one cycle; the cycle it is high is cycle 0.
  task automatic go(input logic [4:0] r, input logic [4:0] g, input logic [4:0] b);
    cr = r; cg = g; cb = b;
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out", {motor, busy, done, aborted, fase}, 9'd0);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    @(negedge clk);

    // Scenario 1: R=3 G=1 B=2
    go(5'd3, 5'd1, 5'd2);
    wait_to(1);  chk("s1_first",  {busy, motor}, 4'b1100);
    wait_to(12); chk("s1_r_last", motor, 3'b100);
    wait_to(13); chk("s1_gap1",   {motor, fase}, {3'b000, 3'd4});
    wait_to(15); chk("s1_g",      motor, 3'b010);
    wait_to(19); chk("s1_gap2",   motor, 3'b000);
    wait_to(21); chk("s1_b",      motor, 3'b001);
    wait_to(28); chk("s1_b_last", {busy, motor}, 4'b1001);
    wait_to(29); chk("s1_done",   {busy, done}, 2'b01);
    wait_to(30); chk("s1_after",  done, 1'b0);

    // Scenario 2: only G, no gaps
    go(5'd0, 5'd2, 5'd0);
    wait_to(1); chk("s2_first", motor, 3'b010);
    wait_to(8); chk("s2_last",  motor, 3'b010);
    wait_to(9); chk("s2_done",  {motor, done}, 4'b0001);
    wait_to(10);

    // Scenario 3: all zero
    go(5'd0, 5'd0, 5'd0);
    wait_to(1); chk("s3_done", {busy, done, motor}, 5'b01000);
    wait_to(2); chk("s3_after", {busy, done}, 2'b00);

    // Scenario 4: abort at cycle 6
    go(5'd3, 5'd1, 5'd2);
    wait_to(6);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("s4_abort", {motor, busy, aborted, done}, 6'b000010);
    wait_to(40);

    // Scenario 5: start re-pulsed and amounts changed mid-run
    go(5'd3, 5'd1, 5'd2);
    wait_to(5);
    start = 1'b1; cr = 5'd7; cg = 5'd0; cb = 5'd9;
    @(negedge clk);
    start = 1'b0;
    wait_to(15); chk("s5_g",    motor, 3'b010);
    wait_to(21); chk("s5_b",    motor, 3'b001);
    wait_to(29); chk("s5_done", {busy, done}, 2'b01);
    wait_to(31);

    // Scenario 6: asynchronous reset mid-run
    go(5'd3, 5'd1, 5'd2);
    wait_to(10);
    #2 rst_n = 1'b0;
    #1 chk("s6_async_rst", {motor, busy, done, aborted, fase}, 9'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    go(5'd1, 5'd0, 5'd0);
    wait_to(4); chk("s6_r",    motor, 3'b100);
    wait_to(5); chk("s6_done", {motor, done}, 4'b0001);
    wait_to(6);

    // Randomized soak: noisy start/abort and constantly changing amounts
    repeat (4000) begin
      @(negedge clk);
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 149) == 0);
      cr = ($urandom_range(0, 29) == 0) ? 5'd31 : 5'($urandom_range(0, 4));
      cg = 5'($urandom_range(0, 4));
      cb = 5'($urandom_range(0, 4));
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
